line_buffer_ctrl: RTL and testbench

//  Control block that writes and reads the Sobel front-end's bank of four Line_Buffer instances.

---
 rtl/line_buffer_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
//----------------------------------------------------------------------------
// line_buffer_ctrl
//
// Drives a bank of four Line_Buffer instances for the Sobel front-end.
//
// Write side: the raw pixel stream is steered into one buffer at a time.
// After LINE_W pixels the target advances to the next buffer, cycling 0..3.
//
// Read side: once three full lines are held, and downstream is ready, three
// buffers are read together for LINE_W cycles. Each read cycle registers one
// 3x3 window for the Sobel kernel. A one-cycle interrupt marks every line
// that has been consumed.
//
// Ports
//   Clk            rising-edge clock
//   Rst_n          asynchronous active-low reset
//   pixel_valid_in pixel_in carries a pixel this cycle
//   pixel_in       incoming pixel
//   proc_ready_in  downstream can take a full line of windows
//   lb_data_out    pixel broadcast to all buffers (combinational)
//   lb_wr_en_out   one-hot write enable for buffers 0..3
//   lb_rd_en_out   read-advance enables for buffers 0..3
//   lb_rd_data0..3 three-pixel read data of buffers 0..3 (combinational)
//   window_out     {top, mid, bot}, with top in the most significant 24 bits
//   window_valid   window_out was loaded on the previous read cycle
//   intr_out       one-cycle pulse after each line is fully read
//   overflow_out   sticky flag: a pixel arrived while storage was full
//----------------------------------------------------------------------------
module line_buffer_ctrl #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned PIX_W  = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 pixel_valid_in,
    input  logic [PIX_W-1:0]     pixel_in,
    input  logic                 proc_ready_in,
    output logic [PIX_W-1:0]     lb_data_out,
    output logic [3:0]           lb_wr_en_out,
    output logic [3:0]           lb_rd_en_out,
    input  logic [3*PIX_W-1:0]   lb_rd_data0,
    input  logic [3*PIX_W-1:0]   lb_rd_data1,
    input  logic [3*PIX_W-1:0]   lb_rd_data2,
    input  logic [3*PIX_W-1:0]   lb_rd_data3,
    output logic [9*PIX_W-1:0]   window_out,
    output logic                 window_valid,
    output logic                 intr_out,
    output logic                 overflow_out
);

    localparam int unsigned CNT_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned FILL_W = $clog2(4 * LINE_W) + 1;

    localparam logic [CNT_W-1:0]  LAST_POS   = CNT_W'(LINE_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4 * LINE_W);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * LINE_W);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_LINE = 1'b1
    } state_t;

    state_t               state;
    logic [1:0]           wr_sel;
    logic [1:0]           rd_sel;
    logic [CNT_W-1:0]     wr_cnt;
    logic [CNT_W-1:0]     rd_cnt;
    logic [FILL_W-1:0]    fill_cnt;

    logic                 wr_fire;
    logic                 rd_fire;
    logic [1:0]           rd_sel_p1;
    logic [1:0]           rd_sel_p2;
    logic [3*PIX_W-1:0]   rd_data [4];
    logic [3*PIX_W-1:0]   row_top;
    logic [3*PIX_W-1:0]   row_mid;
    logic [3*PIX_W-1:0]   row_bot;

    // Three consecutive buffers starting at sel, wrapping modulo 4.
    function automatic logic [3:0] rd_mask(input logic [1:0] sel);
        logic [1:0] s1;
        logic [1:0] s2;
        logic [3:0] m;
        s1     = sel + 2'd1;
        s2     = sel + 2'd2;
        m      = '0;
        m[sel] = 1'b1;
        m[s1]  = 1'b1;
        m[s2]  = 1'b1;
        return m;
    endfunction

    //------------------------------------------------------------------------
    // Write side
    //------------------------------------------------------------------------
    assign lb_data_out = pixel_in;

    // The enable is also held low during reset, so a pixel that arrives
    // while reset is asserted is not written into the buffers.
    assign wr_fire      = pixel_valid_in & Rst_n;
    assign lb_wr_en_out = wr_fire ? (4'b0001 << wr_sel) : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_cnt       <= '0;
            wr_sel       <= '0;
            overflow_out <= 1'b0;
        end else if (pixel_valid_in) begin
            if (wr_cnt == LAST_POS) begin
                wr_cnt <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (fill_cnt == FILL_FULL) begin
                overflow_out <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Storage occupancy in pixels
    //------------------------------------------------------------------------
    // Each read cycle frees one pixel of the oldest line. The count saturates
    // when full; the write that arrives then still overwrites the oldest line.
    assign rd_fire = (state == RD_LINE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fill_cnt <= '0;
        end else begin
            unique case ({pixel_valid_in, rd_fire})
                2'b10: begin
                    if (fill_cnt != FILL_FULL) begin
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    end
                end
                2'b01:   fill_cnt <= fill_cnt - FILL_W'(1);
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Read side: window assembly
    //------------------------------------------------------------------------
    assign rd_data[0] = lb_rd_data0;
    assign rd_data[1] = lb_rd_data1;
    assign rd_data[2] = lb_rd_data2;
    assign rd_data[3] = lb_rd_data3;

    assign rd_sel_p1 = rd_sel + 2'd1;
    assign rd_sel_p2 = rd_sel + 2'd2;

    assign row_top = rd_data[rd_sel];
    assign row_mid = rd_data[rd_sel_p1];
    assign row_bot = rd_data[rd_sel_p2];

    //------------------------------------------------------------------------
    // Read FSM with registered outputs
    //------------------------------------------------------------------------
    // lb_rd_en_out is loaded on entry to RD_LINE and cleared on exit, so it
    // is high for exactly the LINE_W cycles spent in RD_LINE. The return to
    // IDLE always costs one cycle, which separates successive line reads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            rd_sel       <= '0;
            rd_cnt       <= '0;
            lb_rd_en_out <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            intr_out     <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            intr_out     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if ((fill_cnt >= FILL_START) && proc_ready_in) begin
                        state        <= RD_LINE;
                        lb_rd_en_out <= rd_mask(rd_sel);
                    end
                end
                RD_LINE: begin
                    window_out   <= {row_top, row_mid, row_bot};
                    window_valid <= 1'b1;
                    if (rd_cnt == LAST_POS) begin
                        rd_cnt       <= '0;
                        rd_sel       <= rd_sel + 2'd1;
                        intr_out     <= 1'b1;
                        lb_rd_en_out <= '0;
                        state        <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    lb_rd_en_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
module tb_line_buffer_ctrl;

    localparam int unsigned LINE_W = 512;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned STRM_N = 16384;

    logic                 Clk = 1'b0;
    logic                 Rst_n = 1'b1;
    logic                 pixel_valid_in = 1'b0;
    logic [PIX_W-1:0]     pixel_in = '0;
    logic                 proc_ready_in = 1'b0;
    logic [PIX_W-1:0]     lb_data_out;
    logic [3:0]           lb_wr_en_out;
    logic [3:0]           lb_rd_en_out;
    logic [3*PIX_W-1:0]   lb_rd_data0;
    logic [3*PIX_W-1:0]   lb_rd_data1;
    logic [3*PIX_W-1:0]   lb_rd_data2;
    logic [3*PIX_W-1:0]   lb_rd_data3;
    logic [9*PIX_W-1:0]   window_out;
    logic                 window_valid;
    logic                 intr_out;
    logic                 overflow_out;

    always #5 Clk = ~Clk;

    line_buffer_ctrl #(
        .LINE_W (LINE_W),
        .PIX_W  (PIX_W)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .pixel_valid_in (pixel_valid_in),
        .pixel_in       (pixel_in),
        .proc_ready_in  (proc_ready_in),
        .lb_data_out    (lb_data_out),
        .lb_wr_en_out   (lb_wr_en_out),
        .lb_rd_en_out   (lb_rd_en_out),
        .lb_rd_data0    (lb_rd_data0),
        .lb_rd_data1    (lb_rd_data1),
        .lb_rd_data2    (lb_rd_data2),
        .lb_rd_data3    (lb_rd_data3),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .intr_out       (intr_out),
        .overflow_out   (overflow_out)
    );

    // Four circular line buffers: write pointer, read pointer, and a
    // combinational three-pixel read port that wraps at the line end.
    logic [PIX_W-1:0]   lb_mem [4][LINE_W];
    int unsigned        lb_wp [4];
    int unsigned        lb_rp [4];
    logic [3*PIX_W-1:0] lb_q  [4];

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int b = 0; b < 4; b++) begin
                lb_wp[b] <= 0;
                lb_rp[b] <= 0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (lb_wr_en_out[b]) begin
                    lb_mem[b][lb_wp[b]] <= lb_data_out;
                    lb_wp[b] <= (lb_wp[b] + 1) % LINE_W;
                end
                if (lb_rd_en_out[b]) begin
                    lb_rp[b] <= (lb_rp[b] + 1) % LINE_W;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lb_q[b] = {lb_mem[b][lb_rp[b]],
                       lb_mem[b][(lb_rp[b] + 1) % LINE_W],
                       lb_mem[b][(lb_rp[b] + 2) % LINE_W]};
        end
    end

    assign lb_rd_data0 = lb_q[0];
    assign lb_rd_data1 = lb_q[1];
    assign lb_rd_data2 = lb_q[2];
    assign lb_rd_data3 = lb_q[3];

    // Reference model: pixel history plus line-level bookkeeping.
    logic [PIX_W-1:0] strm [STRM_N];
    int unsigned      m_written;
    int unsigned      m_fill;
    int unsigned      m_reads;
    int unsigned      m_rem;
    logic             m_ovf;
    logic             m_intr;
    logic             m_wv;
    logic [71:0]      m_win;
    logic [71:0]      m_mask;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned tally [16];
    int unsigned intr_cnt;
    int unsigned wv_cnt;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] px(input int unsigned line, input int unsigned pos);
        return strm[(line * LINE_W + (pos % LINE_W)) % STRM_N];
    endfunction

    task automatic clear_tally();
        for (int i = 0; i < 16; i++) tally[i] = 0;
        intr_cnt = 0;
        wv_cnt   = 0;
    endtask

    task automatic model_reset();
        m_written = 0;
        m_fill    = 0;
        m_reads   = 0;
        m_rem     = 0;
        m_ovf     = 1'b0;
        m_intr    = 1'b0;
        m_wv      = 1'b0;
        m_win     = '0;
        m_mask    = '1;
    endtask

    // Asserts reset between clock edges and checks outputs clear at once.
    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        chk("rst_wr_en",   72'(lb_wr_en_out), 72'(0));
        chk("rst_rd_en",   72'(lb_rd_en_out), 72'(0));
        chk("rst_window",  72'(window_out),   72'(0));
        chk("rst_wvalid",  72'(window_valid), 72'(0));
        chk("rst_intr",    72'(intr_out),     72'(0));
        chk("rst_ovf",     72'(overflow_out), 72'(0));
        model_reset();
        pixel_valid_in = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
    endtask

    // One clock of stimulus with model update and output checks.
    task automatic cyc(input logic v, input logic r);
        logic [PIX_W-1:0] p;
        logic             rd;
        int unsigned      old_fill;
        int unsigned      j;
        logic [7:0]       rot;
        logic [3:0]       exp_rd;

        p = PIX_W'($urandom);
        pixel_valid_in = v;
        pixel_in       = p;
        proc_ready_in  = r;
        #1;
        chk("wr_en", 72'(lb_wr_en_out),
            v ? 72'(4'b0001 << ((m_written / LINE_W) % 4)) : 72'(0));
        chk("lb_data", 72'(lb_data_out), 72'(p));

        @(posedge Clk);
        #1;
        rd       = (m_rem != 0);
        old_fill = m_fill;
        m_intr   = 1'b0;
        m_wv     = rd;
        if (rd) begin
            j = LINE_W - m_rem;
            m_win  = '0;
            m_mask = '0;
            for (int unsigned rr = 0; rr < 3; rr++) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    m_win  = {m_win[63:0], px(m_reads + rr, j + k)};
                    m_mask = {m_mask[63:0], (j + k < LINE_W) ? 8'hFF : 8'h00};
                end
            end
            m_rem--;
            if (m_rem == 0) begin
                m_intr = 1'b1;
                m_reads++;
            end
        end else if (old_fill >= 3 * LINE_W && r) begin
            m_rem = LINE_W;
        end
        if (v) begin
            if (old_fill == 4 * LINE_W) m_ovf = 1'b1;
            strm[m_written % STRM_N] = p;
            m_written++;
        end
        if (v && !rd && old_fill < 4 * LINE_W) m_fill = old_fill + 1;
        else if (rd && !v) m_fill = old_fill - 1;

        rot    = {4'b0111, 4'b0111} << (m_reads % 4);
        exp_rd = (m_rem != 0) ? rot[7:4] : 4'b0000;

        chk("rd_en",    72'(lb_rd_en_out), 72'(exp_rd));
        chk("wvalid",   72'(window_valid), 72'(m_wv));
        chk("intr",     72'(intr_out),     72'(m_intr));
        chk("overflow", 72'(overflow_out), 72'(m_ovf));
        chk("window",   window_out & m_mask, m_win & m_mask);

        tally[lb_rd_en_out]++;
        if (intr_out) intr_cnt++;
        if (window_valid) wv_cnt++;
    endtask

    initial begin
        int unsigned busy;
        model_reset();
        clear_tally();
        #2;

        // Power-on reset, then three-line fill followed by reads.
        do_reset();
        clear_tally();
        for (int i = 0; i < 2560; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 1700; i++) cyc(1'b0, 1'b1);
        chk("reads_0111", 72'(tally[4'b0111]), 72'(LINE_W));
        chk("reads_1110", 72'(tally[4'b1110]), 72'(LINE_W));
        chk("reads_1101", 72'(tally[4'b1101]), 72'(LINE_W));
        chk("intr_pulses", 72'(intr_cnt), 72'(3));
        chk("wvalid_cycles", 72'(wv_cnt), 72'(3 * LINE_W));

        // Reset in the middle of an incoming line.
        for (int i = 0; i < 700; i++) cyc(1'($urandom_range(0, 1)), 1'b1);
        pixel_valid_in = 1'b1;
        do_reset();

        // Random pacing with ready toggling, reset mid-run, more random.
        for (int i = 0; i < 3300; i++)
            cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0));
        do_reset();
        for (int i = 0; i < 3300; i++)
            cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) != 0));

        // Storage overflow with downstream never ready.
        do_reset();
        clear_tally();
        for (int i = 0; i < 2049; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
        chk("ovf_sticky", 72'(overflow_out), 72'(1));
        busy = 0;
        for (int i = 1; i < 16; i++) busy += tally[i];
        chk("ovf_no_read", 72'(busy), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
